// File: rtl/hdmi_pkt_if.sv
// Handshake bundle between the HDMI packet scheduler, the video timing
// generator (island_start) and the data-island packet sources (req/grant/ack).
//   island_start   : one-cycle strobe opening a 32-pixel packet slot
//   req            : level requests, one bit per source
//   grant          : one-hot owner of the current slot (zero for a null slot)
//   ack            : one-cycle pulse on the granted bit at the last pixel
//   packet_active  : high for the 32 cycles of a slot
//   packet_counter : pixel index within the packet, 0..31
//   null_packet    : high throughout a slot that no source claimed
//   overrun        : sticky, island_start seen mid-packet
interface hdmi_pkt_if #(
  parameter int NUM_SOURCES = 4
);
  logic                   island_start;
  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] grant;
  logic [NUM_SOURCES-1:0] ack;
  logic                   packet_active;
  logic [4:0]             packet_counter;
  logic                   null_packet;
  logic                   overrun;

  // Scheduler side
  modport slave (
    input  island_start, req,
    output grant, ack, packet_active, packet_counter, null_packet, overrun
  );

  // Timing generator / packet source side
  modport master (
    output island_start, req,
    input  grant, ack, packet_active, packet_counter, null_packet, overrun
  );
endinterface

// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island packet scheduler (clk_pixel domain).
// Arbitrates the packet sources once per island_start and sequences one
// 32-pixel packet slot. Source 0 has strict priority; sources 1..N-1 are
// served round-robin. Slots nobody claims run as null packets.
// Ports:
//   clk_pixel : pixel clock
//   reset_n   : asynchronous active-low reset
//   bus       : hdmi_pkt_if.slave (island_start, req in; grant, ack,
//               packet_active, packet_counter, null_packet, overrun out)
// All outputs are registered.
module hdmi_packet_scheduler #(
  parameter int NUM_SOURCES = 4,
  parameter bit DVI_OUTPUT  = 1'b0
) (
  input  logic      clk_pixel,
  input  logic      reset_n,
  hdmi_pkt_if.slave bus
);

  localparam int PTR_W = $clog2(NUM_SOURCES);
  localparam logic [4:0] LAST_PIX = 5'd31;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state_q, state_d;
  logic [4:0]             cnt_q, cnt_d;
  logic [NUM_SOURCES-1:0] grant_q, grant_d;
  logic [NUM_SOURCES-1:0] ack_q, ack_d;
  logic                   null_q, null_d;
  logic                   overrun_q, overrun_d;
  logic [PTR_W-1:0]       rr_q, rr_d;

  logic                   start;
  logic                   launch;
  logic [NUM_SOURCES-1:0] arb_req;
  logic [NUM_SOURCES-1:0] arb_grant;

  // Strict priority for source 0, then the first set request scanning
  // ptr, ptr+1, ... across 1..N-1 with wrap-around.
  function automatic logic [NUM_SOURCES-1:0] arbitrate(
    input logic [NUM_SOURCES-1:0] r,
    input logic [PTR_W-1:0]       ptr
  );
    logic [NUM_SOURCES-1:0] g;
    int                     idx;
    g = '0;
    if (r[0]) begin
      g[0] = 1'b1;
    end else begin
      for (int k = 0; k < NUM_SOURCES - 1; k++) begin
        idx = ((int'(ptr) - 1 + k) % (NUM_SOURCES - 1)) + 1;
        if (g == '0 && r[idx]) g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  // Pointer moves past a round-robin winner; source 0 or null keeps it.
  function automatic logic [PTR_W-1:0] next_ptr(
    input logic [NUM_SOURCES-1:0] g,
    input logic [PTR_W-1:0]       ptr
  );
    logic [PTR_W-1:0] p;
    p = ptr;
    for (int i = 1; i < NUM_SOURCES; i++) begin
      if (g[i]) p = (i == NUM_SOURCES - 1) ? PTR_W'(1) : PTR_W'(i + 1);
    end
    return p;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    null_d    = null_q;
    ack_d     = '0;
    overrun_d = overrun_q;
    rr_d      = rr_q;

    // In DVI mode the strobe is masked, so the machine never leaves IDLE.
    start     = bus.island_start && !DVI_OUTPUT;
    // A new slot may open from IDLE or on the last pixel of the current one.
    launch    = start && (state_q == IDLE || cnt_q == LAST_PIX);
    // On a back-to-back launch the source being acked this cycle still has
    // its req high; mask it so it cannot win the very next slot.
    arb_req   = (state_q == ACTIVE) ? (bus.req & ~grant_q) : bus.req;
    arb_grant = arbitrate(arb_req, rr_q);

    if (launch) begin
      state_d = ACTIVE;
      cnt_d   = '0;
      grant_d = arb_grant;
      null_d  = (arb_grant == '0);
      rr_d    = next_ptr(arb_grant, rr_q);
    end else if (state_q == ACTIVE) begin
      if (cnt_q == LAST_PIX) begin
        state_d = IDLE;
        cnt_d   = '0;
        grant_d = '0;
        null_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + 5'd1;
        // Registered ack must be loaded one cycle early to appear at pixel 31.
        if (cnt_q == LAST_PIX - 5'd1) ack_d = grant_q;
        if (start) overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      null_q    <= 1'b0;
      overrun_q <= 1'b0;
      rr_q      <= PTR_W'(1);
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      null_q    <= null_d;
      overrun_q <= overrun_d;
      rr_q      <= rr_d;
    end
  end

  assign bus.grant          = grant_q;
  assign bus.ack            = ack_q;
  assign bus.packet_active  = (state_q == ACTIVE);
  assign bus.packet_counter = cnt_q;
  assign bus.null_packet    = null_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler: a table of isolated slots with
// hand-computed grants (round-robin state carries from row to row), then
// hand-written back-to-back, overrun, async-reset and DVI-mode sequences.
module tb_hdmi_packet_scheduler;

  localparam int N = 4;

  logic clk_pixel = 1'b0;
  logic reset_n;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_pkt_if #(.NUM_SOURCES(N)) m_if ();
  hdmi_pkt_if #(.NUM_SOURCES(N)) d_if ();

  hdmi_packet_scheduler #(.NUM_SOURCES(N), .DVI_OUTPUT(1'b0)) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (m_if.slave)
  );

  hdmi_packet_scheduler #(.NUM_SOURCES(N), .DVI_OUTPUT(1'b1)) dut_dvi (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .bus       (d_if.slave)
  );

  // DVI instance sees every island strobe with all sources requesting.
  assign d_if.island_start = m_if.island_start;
  assign d_if.req          = 4'b1111;

  int total = 0;
  int bad   = 0;
  int dvi_bad = 0;

  always @(negedge clk_pixel) begin
    if ({d_if.grant, d_if.ack, d_if.packet_active, d_if.packet_counter,
         d_if.null_packet, d_if.overrun} !== 16'h0)
      dvi_bad++;
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] grant;
    logic       nul;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] outs_m();
    return {m_if.grant, m_if.ack, m_if.packet_active, m_if.packet_counter,
            m_if.null_packet, m_if.overrun};
  endfunction

  // Opens one isolated slot with request vector r and checks it end to end.
  task automatic run_slot(input logic [3:0] r, input logic [3:0] eg,
                          input logic en, input int id);
    int errs;
    int early;
    errs  = 0;
    early = 0;
    @(negedge clk_pixel);
    m_if.req          = r;
    m_if.island_start = 1'b1;
    @(negedge clk_pixel);
    m_if.island_start = 1'b0;
    chk($sformatf("v%0d grant", id), 32'(m_if.grant), 32'(eg));
    chk($sformatf("v%0d null", id), 32'(m_if.null_packet), 32'(en));
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk_pixel);
      if (m_if.packet_counter !== 5'(k) || m_if.packet_active !== 1'b1 ||
          m_if.grant !== eg || m_if.null_packet !== en)
        errs++;
      if (k < 31 && m_if.ack !== 4'b0000) early++;
      if (k == 31) chk($sformatf("v%0d ack", id), 32'(m_if.ack), 32'(eg));
    end
    chk($sformatf("v%0d slot_hold", id), 32'(errs), 32'd0);
    chk($sformatf("v%0d ack_early", id), 32'(early), 32'd0);
    @(negedge clk_pixel);
    chk($sformatf("v%0d idle", id), 32'(outs_m() & 16'hFFFE), 32'd0);
  endtask

  initial begin
    int errs;
    int acks;

    // rr pointer starts at 1 and evolves row to row.
    tbl[0] = '{req: 4'b0000, grant: 4'b0000, nul: 1'b1}; // null, rr 1
    tbl[1] = '{req: 4'b1011, grant: 4'b0001, nul: 1'b0}; // priority, rr 1
    tbl[2] = '{req: 4'b1110, grant: 4'b0010, nul: 1'b0}; // rr -> 2
    tbl[3] = '{req: 4'b1110, grant: 4'b0100, nul: 1'b0}; // rr -> 3
    tbl[4] = '{req: 4'b1110, grant: 4'b1000, nul: 1'b0}; // rr -> 1 (wrap)
    tbl[5] = '{req: 4'b1110, grant: 4'b0010, nul: 1'b0}; // rr -> 2
    tbl[6] = '{req: 4'b1001, grant: 4'b0001, nul: 1'b0}; // priority, rr 2
    tbl[7] = '{req: 4'b0010, grant: 4'b0010, nul: 1'b0}; // wrap scan, rr 2
    tbl[8] = '{req: 4'b1010, grant: 4'b1000, nul: 1'b0}; // rr -> 1
    tbl[9] = '{req: 4'b0100, grant: 4'b0100, nul: 1'b0}; // rr -> 3

    reset_n           = 1'b0;
    m_if.island_start = 1'b0;
    m_if.req          = 4'b0000;
    repeat (3) @(negedge clk_pixel);
    chk("reset outs", 32'(outs_m()), 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge clk_pixel);

    for (int i = 0; i < 10; i++)
      run_slot(tbl[i].req, tbl[i].grant, tbl[i].nul, i);

    // Back-to-back: rr=3, req 0110 -> source 1, then source 2 excluding 1.
    @(negedge clk_pixel);
    m_if.req          = 4'b0110;
    m_if.island_start = 1'b1;
    @(negedge clk_pixel);
    m_if.island_start = 1'b0;
    chk("b2b grant1", 32'(m_if.grant), 32'h2);
    errs = 0;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk_pixel);
      if (m_if.packet_active !== 1'b1) errs++;
      if (k == 31) begin
        chk("b2b ack1", 32'(m_if.ack), 32'h2);
        m_if.island_start = 1'b1;
      end
    end
    @(negedge clk_pixel);
    m_if.island_start = 1'b0;
    chk("b2b cnt0", 32'(m_if.packet_counter), 32'd0);
    chk("b2b grant2", 32'(m_if.grant), 32'h4);
    chk("b2b active", 32'(m_if.packet_active), 32'd1);
    chk("b2b ack_clr", 32'(m_if.ack), 32'd0);
    for (int k = 1; k < 32; k++) begin
      @(negedge clk_pixel);
      if (m_if.packet_active !== 1'b1 || m_if.grant !== 4'b0100) errs++;
      if (k == 31) begin
        chk("b2b ack2", 32'(m_if.ack), 32'h4);
        m_if.req = 4'b0000;
      end
    end
    chk("b2b no_drop", 32'(errs), 32'd0);
    chk("b2b overrun", 32'(m_if.overrun), 32'd0);
    @(negedge clk_pixel);
    chk("b2b idle", 32'(outs_m()), 32'd0);

    // Overrun: island_start at counter 7 is ignored but flagged.
    @(negedge clk_pixel);
    m_if.req          = 4'b0001;
    m_if.island_start = 1'b1;
    @(negedge clk_pixel);
    m_if.island_start = 1'b0;
    for (int k = 1; k < 32; k++) begin
      @(negedge clk_pixel);
      if (k == 7) m_if.island_start = 1'b1;
      if (k == 8) begin
        m_if.island_start = 1'b0;
        chk("ovr flag", 32'(m_if.overrun), 32'd1);
        chk("ovr cnt", 32'(m_if.packet_counter), 32'd8);
        chk("ovr grant", 32'(m_if.grant), 32'h1);
      end
      if (k == 31) chk("ovr ack", 32'(m_if.ack), 32'h1);
    end
    @(negedge clk_pixel);
    chk("ovr sticky", 32'(outs_m()), 32'd1);

    // Async reset mid-slot at counter 15.
    @(negedge clk_pixel);
    m_if.island_start = 1'b1;
    @(negedge clk_pixel);
    m_if.island_start = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk_pixel);
    chk("arst pre cnt", 32'(m_if.packet_counter), 32'd15);
    reset_n = 1'b0;
    #1;
    chk("arst outs", 32'(outs_m()), 32'd0);
    acks = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_pixel);
      if (k == 3) reset_n = 1'b1;
      if (m_if.ack !== 4'b0000 || m_if.packet_active !== 1'b0) acks++;
    end
    chk("arst no_ack", 32'(acks), 32'd0);

    // Pointer back at 1 after reset: 1100 scans 1,2 -> source 2.
    run_slot(4'b1100, 4'b0100, 1'b0, 20);

    chk("dvi quiet", 32'(dvi_bad), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
